// File: rtl/id_exe_ctrl.sv
// ============================================================================
// id_exe_ctrl
// ----------------------------------------------------------------------------
// Instruction decode control generator and ID/EXE pipeline register for the
// RV32I core. It decodes the ID-stage instruction into an ALU-operation class,
// the funct3/funct7 fields and the datapath control bits. These are registered
// into EXE under flush/stall control. An optional load-use hazard detector
// inserts a one-cycle bubble and asks IF/ID to hold.
//
// Configuration macro:
//   HAZARD_DETECT_EN  defined   -> load-use detection and bubble insertion
//                     undefined -> id_stall_req tied 0, no hazard bubbles
//
// Ports:
//   clk            in   core clock, rising edge
//   rst_n          in   asynchronous active-low reset
//   id_inst[31:0]  in   ID-stage instruction
//   id_valid       in   id_inst holds a real instruction
//   stall          in   external freeze; EXE registers hold
//   flush          in   redirect; next EXE entry is a bubble
//   id_stall_req   out  load-use hazard, IF/ID hold (combinational)
//   exe_valid      out  EXE holds a real instruction
//   exe_alu_op     out  000 R, 001 I-ALU, 010 add, 011 jal/jalr, 100 branch,
//                       110 lui (also reported for an illegal opcode)
//   exe_funct3     out  inst[14:12]
//   exe_funct7     out  inst[31:25] for R-type and I-type shifts, else 0
//   exe_rd/rs1/rs2 out  register specifiers
//   exe_reg_write, exe_mem_read, exe_mem_write, exe_branch, exe_jump,
//   exe_pc_src_a, exe_imm_src_b  out  datapath controls
//   exe_illegal    out  unrecognised opcode captured
// ============================================================================
module id_exe_ctrl (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] id_inst,
    input  logic        id_valid,
    input  logic        stall,
    input  logic        flush,
    output logic        id_stall_req,
    output logic        exe_valid,
    output logic [2:0]  exe_alu_op,
    output logic [2:0]  exe_funct3,
    output logic [6:0]  exe_funct7,
    output logic [4:0]  exe_rd,
    output logic [4:0]  exe_rs1,
    output logic [4:0]  exe_rs2,
    output logic        exe_reg_write,
    output logic        exe_mem_read,
    output logic        exe_mem_write,
    output logic        exe_branch,
    output logic        exe_jump,
    output logic        exe_pc_src_a,
    output logic        exe_imm_src_b,
    output logic        exe_illegal
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] ALU_R      = 3'b000;
    localparam logic [2:0] ALU_I      = 3'b001;
    localparam logic [2:0] ALU_ADD    = 3'b010;
    localparam logic [2:0] ALU_JUMP   = 3'b011;
    localparam logic [2:0] ALU_BRANCH = 3'b100;
    localparam logic [2:0] ALU_LUI    = 3'b110;

    typedef struct packed {
        logic       valid;
        logic [2:0] alu_op;
        logic [2:0] funct3;
        logic [6:0] funct7;
        logic [4:0] rd;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       branch;
        logic       jump;
        logic       pc_src_a;
        logic       imm_src_b;
        logic       illegal;
    } ctrl_t;

    ctrl_t dec;      // decoded ID instruction
    ctrl_t exe_q;    // EXE-stage register
    ctrl_t exe_d;
    logic  use_rs1;
    logic  use_rs2;
    logic  load_use;

    // ------------------------------------------------------------------
    // Decode of the ID-stage instruction
    // ------------------------------------------------------------------
    // NOTE: every output of this block gets a default first, so no path
    // leaves a signal unassigned and no latch is inferred.
    always_comb begin
        dec        = '0;
        use_rs1    = 1'b0;
        use_rs2    = 1'b0;
        dec.valid  = 1'b1;
        dec.funct3 = id_inst[14:12];
        dec.rd     = id_inst[11:7];
        dec.rs1    = id_inst[19:15];
        dec.rs2    = id_inst[24:20];
        unique case (id_inst[6:0])
            OP_R: begin
                dec.alu_op    = ALU_R;
                dec.funct7    = id_inst[31:25];
                dec.reg_write = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OP_I: begin
                dec.alu_op    = ALU_I;
                // Only the shift-immediates carry a meaningful funct7.
                if (id_inst[13:12] == 2'b01)
                    dec.funct7 = id_inst[31:25];
                dec.reg_write = 1'b1;
                dec.imm_src_b = 1'b1;
                use_rs1       = 1'b1;
            end
            OP_LOAD: begin
                dec.alu_op    = ALU_ADD;
                dec.mem_read  = 1'b1;
                dec.reg_write = 1'b1;
                dec.imm_src_b = 1'b1;
                use_rs1       = 1'b1;
            end
            OP_STORE: begin
                dec.alu_op    = ALU_ADD;
                dec.mem_write = 1'b1;
                dec.imm_src_b = 1'b1;
                use_rs1       = 1'b1;
                use_rs2       = 1'b1;
            end
            OP_BRANCH: begin
                dec.alu_op = ALU_BRANCH;
                dec.branch = 1'b1;
                use_rs1    = 1'b1;
                use_rs2    = 1'b1;
            end
            OP_JAL: begin
                dec.alu_op    = ALU_JUMP;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                dec.pc_src_a  = 1'b1;
            end
            OP_JALR: begin
                dec.alu_op    = ALU_JUMP;
                dec.jump      = 1'b1;
                dec.reg_write = 1'b1;
                use_rs1       = 1'b1;
            end
            OP_LUI: begin
                dec.alu_op    = ALU_LUI;
                dec.reg_write = 1'b1;
                dec.imm_src_b = 1'b1;
            end
            OP_AUIPC: begin
                dec.alu_op    = ALU_ADD;
                dec.reg_write = 1'b1;
                dec.pc_src_a  = 1'b1;
                dec.imm_src_b = 1'b1;
            end
            default: begin
                // Captured as an invalid entry so the trap logic can see it.
                dec.valid   = 1'b0;
                dec.alu_op  = ALU_LUI;
                dec.illegal = 1'b1;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Load-use hazard: a load in EXE writes a register the ID instruction
    // reads. Writes to x0 never create a dependency.
    // ------------------------------------------------------------------
`ifdef HAZARD_DETECT_EN
    assign load_use = exe_q.valid && exe_q.mem_read && (exe_q.rd != 5'd0) && id_valid &&
                      ((use_rs1 && (dec.rs1 == exe_q.rd)) ||
                       (use_rs2 && (dec.rs2 == exe_q.rd)));
`else
    logic unused_rs_use;
    assign unused_rs_use = &{1'b0, use_rs1, use_rs2};
    assign load_use      = 1'b0;
`endif

    // A frozen or redirected pipeline never needs IF/ID held for a hazard.
    assign id_stall_req = load_use && !stall && !flush;

    // ------------------------------------------------------------------
    // Next EXE entry: flush > stall > hazard > load
    // ------------------------------------------------------------------
    always_comb begin
        exe_d = exe_q;
        if (flush)
            exe_d = '0;
        else if (stall)
            exe_d = exe_q;
        else if (load_use || !id_valid)
            exe_d = '0;
        else
            exe_d = dec;
    end

    // NOTE: state registers use non-blocking assignments and clear on the
    // asynchronous reset, so no stale hazard survives a reset mid-stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            exe_q <= '0;
        else
            exe_q <= exe_d;
    end

    assign exe_valid     = exe_q.valid;
    assign exe_alu_op    = exe_q.alu_op;
    assign exe_funct3    = exe_q.funct3;
    assign exe_funct7    = exe_q.funct7;
    assign exe_rd        = exe_q.rd;
    assign exe_rs1       = exe_q.rs1;
    assign exe_rs2       = exe_q.rs2;
    assign exe_reg_write = exe_q.reg_write;
    assign exe_mem_read  = exe_q.mem_read;
    assign exe_mem_write = exe_q.mem_write;
    assign exe_branch    = exe_q.branch;
    assign exe_jump      = exe_q.jump;
    assign exe_pc_src_a  = exe_q.pc_src_a;
    assign exe_imm_src_b = exe_q.imm_src_b;
    assign exe_illegal   = exe_q.illegal;

endmodule

// File: tb/tb_id_exe_ctrl.sv
// Self-checking bench for id_exe_ctrl: directed test-plan steps followed by
// randomized traffic, all compared against a behavioural EXE-stage model.
module tb_id_exe_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] id_inst = '0;
    logic        id_valid = 1'b0;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        id_stall_req, exe_valid;
    logic [2:0]  exe_alu_op, exe_funct3;
    logic [6:0]  exe_funct7;
    logic [4:0]  exe_rd, exe_rs1, exe_rs2;
    logic        exe_reg_write, exe_mem_read, exe_mem_write, exe_branch;
    logic        exe_jump, exe_pc_src_a, exe_imm_src_b, exe_illegal;

    int tests = 0;
    int fails = 0;

    id_exe_ctrl dut (
        .clk(clk), .rst_n(rst_n), .id_inst(id_inst), .id_valid(id_valid),
        .stall(stall), .flush(flush), .id_stall_req(id_stall_req),
        .exe_valid(exe_valid), .exe_alu_op(exe_alu_op), .exe_funct3(exe_funct3),
        .exe_funct7(exe_funct7), .exe_rd(exe_rd), .exe_rs1(exe_rs1), .exe_rs2(exe_rs2),
        .exe_reg_write(exe_reg_write), .exe_mem_read(exe_mem_read),
        .exe_mem_write(exe_mem_write), .exe_branch(exe_branch), .exe_jump(exe_jump),
        .exe_pc_src_a(exe_pc_src_a), .exe_imm_src_b(exe_imm_src_b),
        .exe_illegal(exe_illegal)
    );

    always #5 clk = ~clk;

    // Expected EXE contents, in a fixed order used for whole-stage comparison.
    typedef struct packed {
        logic       valid;
        logic [2:0] alu_op;
        logic [2:0] f3;
        logic [6:0] f7;
        logic [4:0] rd, rs1, rs2;
        logic       rw, mr, mw, br, jp, pa, ib, ill;
    } exe_t;

    exe_t m = '0;

    function automatic logic [36:0] dut_vec();
        return {exe_valid, exe_alu_op, exe_funct3, exe_funct7, exe_rd, exe_rs1, exe_rs2,
                exe_reg_write, exe_mem_read, exe_mem_write, exe_branch, exe_jump,
                exe_pc_src_a, exe_imm_src_b, exe_illegal};
    endfunction

    // Reference decode straight from the opcode table.
    function automatic exe_t decode_ref(input logic [31:0] i);
        exe_t e = '0;
        e.valid = 1'b1;
        e.f3 = i[14:12]; e.rd = i[11:7]; e.rs1 = i[19:15]; e.rs2 = i[24:20];
        case (i[6:0])
            7'h33: begin e.alu_op = 3'd0; e.rw = 1; e.f7 = i[31:25]; end
            7'h13: begin e.alu_op = 3'd1; e.rw = 1; e.ib = 1;
                         if (i[14:12] == 3'd1 || i[14:12] == 3'd5) e.f7 = i[31:25]; end
            7'h03: begin e.alu_op = 3'd2; e.mr = 1; e.rw = 1; e.ib = 1; end
            7'h23: begin e.alu_op = 3'd2; e.mw = 1; e.ib = 1; end
            7'h63: begin e.alu_op = 3'd4; e.br = 1; end
            7'h6F: begin e.alu_op = 3'd3; e.jp = 1; e.rw = 1; e.pa = 1; end
            7'h67: begin e.alu_op = 3'd3; e.jp = 1; e.rw = 1; end
            7'h37: begin e.alu_op = 3'd6; e.rw = 1; e.ib = 1; end
            7'h17: begin e.alu_op = 3'd2; e.rw = 1; e.pa = 1; e.ib = 1; end
            default: begin e.valid = 0; e.alu_op = 3'd6; e.ill = 1; end
        endcase
        return e;
    endfunction

    function automatic logic hazard_ref();
`ifdef HAZARD_DETECT_EN
        logic [6:0] op = id_inst[6:0];
        logic r1 = op inside {7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h67};
        logic r2 = op inside {7'h33, 7'h23, 7'h63};
        return m.valid && m.mr && m.rd != 0 && id_valid &&
               ((r1 && id_inst[19:15] == m.rd) || (r2 && id_inst[24:20] == m.rd));
`else
        return 1'b0;
`endif
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Apply inputs, check the combinational stall request, clock once,
    // advance the model and compare the whole EXE stage.
    task automatic step(input string tag, input logic [31:0] inst, input logic v,
                        input logic st, input logic fl);
        logic hz;
        id_inst = inst; id_valid = v; stall = st; flush = fl;
        #1;
        hz = hazard_ref();
        check({tag, "_stall_req"}, 64'(id_stall_req), 64'(hz && !st && !fl));
        @(posedge clk);
        if (fl)                  m = '0;
        else if (st)             m = m;
        else if (hz || !v)       m = '0;
        else                     m = decode_ref(inst);
        #1;
        check({tag, "_exe"}, 64'(dut_vec()), 64'(m));
    endtask

    localparam logic [31:0] ADD_X3   = 32'h002081B3;
    localparam logic [31:0] SRAI_X4  = 32'h40325213;
    localparam logic [31:0] ADDI_X4  = 32'hFFF20213;
    localparam logic [31:0] LW_X5    = 32'h0000A283;
    localparam logic [31:0] ADD_X6   = 32'h00128333;  // add x6,x5,x1
    localparam logic [31:0] LW_X0    = 32'h0000A003;
    localparam logic [31:0] ADD_X6_0 = 32'h00100333;  // add x6,x0,x1
    localparam logic [31:0] ILLEGAL  = 32'h0000007F;

    logic [6:0] opcs [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63,
                              7'h6F, 7'h67, 7'h37, 7'h17, 7'h7F};

    initial begin
        logic [31:0] r;

        // Reset state
        #2;
        check("reset_exe", 64'(dut_vec()), 64'd0);
        check("reset_stall_req", 64'(id_stall_req), 64'd0);
        @(negedge clk); rst_n = 1'b1;

        // add x3,x1,x2
        step("add", ADD_X3, 1, 0, 0);
        check("add_alu_op", 64'(exe_alu_op), 64'd0);
        check("add_rd", 64'(exe_rd), 64'd3);
        check("add_valid_rw", 64'({exe_valid, exe_reg_write}), 64'b11);

        // srai / addi funct7 handling
        step("srai", SRAI_X4, 1, 0, 0);
        check("srai_fields", 64'({exe_alu_op, exe_funct3, exe_funct7}),
              64'({3'b001, 3'b101, 7'b0100000}));
        step("addi", ADDI_X4, 1, 0, 0);
        check("addi_funct7", 64'(exe_funct7), 64'd0);

        // Load-use pair
        step("lw", LW_X5, 1, 0, 0);
`ifdef HAZARD_DETECT_EN
        step("lu_bubble", ADD_X6, 1, 0, 0);
        check("lu_bubble_valid", 64'(exe_valid), 64'd0);
        step("lu_add", ADD_X6, 1, 0, 0);
`else
        step("lu_add", ADD_X6, 1, 0, 0);
`endif
        check("lu_add_rd", 64'({exe_valid, exe_rd}), 64'({1'b1, 5'd6}));
        // Load to x0 never stalls
        step("lw_x0", LW_X0, 1, 0, 0);
        step("add_x0", ADD_X6_0, 1, 0, 0);
        check("add_x0_valid", 64'(exe_valid), 64'd1);

        // Stall for three cycles with new instructions offered
        step("stall1", SRAI_X4, 1, 1, 0);
        step("stall2", LW_X5, 1, 1, 0);
        step("stall3", ADDI_X4, 1, 1, 0);
        check("stall_hold", 64'({exe_valid, exe_rd, exe_rs1}), 64'({1'b1, 5'd6, 5'd0}));
        step("stall_flush", ADD_X3, 1, 1, 1);
        check("stall_flush_valid", 64'(exe_valid), 64'd0);

        // Flush together with a load-use hazard
        step("lw2", LW_X5, 1, 0, 0);
        step("flush_hz", ADD_X6, 1, 0, 1);

        // Illegal opcode, then a legal instruction clears it
        step("illegal", ILLEGAL, 1, 0, 0);
        check("illegal_bits", 64'({exe_illegal, exe_valid, exe_reg_write, exe_alu_op}),
              64'({1'b1, 1'b0, 1'b0, 3'b110}));
        step("after_illegal", ADD_X3, 1, 0, 0);
        check("illegal_cleared", 64'(exe_illegal), 64'd0);

        // Reset asserted mid-stall with a pending hazard
        step("lw3", LW_X5, 1, 0, 0);
        id_inst = ADD_X6; id_valid = 1; stall = 1;
        #2;
        rst_n = 1'b0;
        #1;
        m = '0;
        check("midreset_exe", 64'(dut_vec()), 64'd0);
        check("midreset_stall_req", 64'(id_stall_req), 64'd0);
        @(negedge clk); rst_n = 1'b1; stall = 0;
        step("post_reset", ADD_X6, 1, 0, 0);

        // Randomized traffic; small register range makes hazards frequent
        for (int n = 0; n < 500; n++) begin
            r = $urandom;
            r[6:0]   = opcs[$urandom_range(0, 9)];
            r[11:7]  = 5'($urandom_range(0, 3));
            r[19:15] = 5'($urandom_range(0, 3));
            r[24:20] = 5'($urandom_range(0, 3));
            step("rand", r, ($urandom_range(0, 7) != 0), ($urandom_range(0, 7) == 0),
                 ($urandom_range(0, 9) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/id_exe_ctrl.md
# id_exe_ctrl

Instruction decode control generator and ID/EXE pipeline register for the RV32I core. It decodes the ID-stage instruction into the ALU-operation class, funct3 and funct7 fields, and the datapath control bits. It registers them into the EXE stage under stall and flush control. It also detects load-use hazards against the instruction currently in EXE and inserts a bubble.

## Interface
Parameters:
- None.

Ports:
- clk  in  1  core clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- id_inst  in  32  instruction in the ID stage.
- id_valid  in  1  id_inst holds a real instruction.
- stall  in  1  external pipeline freeze (memory wait); EXE registers hold their value.
- flush  in  1  branch/jump redirect; the next EXE entry is a bubble.
- id_stall_req  out  1  load-use hazard; IF and ID must hold this cycle (combinational).
- exe_valid  out  1  EXE holds a real instruction.
- exe_alu_op  out  3  000 R, 001 I-ALU, 010 add (load/store/auipc), 011 jalr/jal, 100 branch, 110 lui.
- exe_funct3  out  3  inst[14:12].
- exe_funct7  out  7  inst[31:25] for R-type and I-type shifts (funct3 001/101); otherwise 0.
- exe_rd, exe_rs1, exe_rs2  out  5 each  inst[11:7], [19:15], [24:20].
- exe_reg_write, exe_mem_read, exe_mem_write, exe_branch, exe_jump, exe_pc_src_a, exe_imm_src_b  out  1 each  datapath controls.
- exe_illegal  out  1  unrecognised opcode captured.

## Operation
- Opcode decode:
  - 0110011 → R (reg_write).
  - 0010011 → I (reg_write, imm_src_b).
  - 0000011 → add (mem_read, reg_write, imm_src_b).
  - 0100011 → add (mem_write, imm_src_b).
  - 1100011 → branch.
  - 1101111 jal → 011 (jump, reg_write, pc_src_a).
  - 1100111 jalr → 011 (jump, reg_write).
  - 0110111 → lui (reg_write, imm_src_b).
  - 0010111 auipc → add (reg_write, pc_src_a, imm_src_b).
- Illegal opcode: exe_illegal=1, exe_valid=0, all write/mem/branch/jump bits 0, exe_alu_op=110.
- Register usage: rs1 is used by R, I, load, store, branch and jalr; rs2 is used by R, store and branch.
- Load-use hazard is active when all of the following hold:
  - exe_valid & exe_mem_read & exe_rd≠0 & id_valid;
  - the ID instruction uses rs1 with rs1==exe_rd, or uses rs2 with rs2==exe_rd.
- Update priority each edge: flush > stall > hazard > load.
  - flush: load a bubble.
  - stall: hold all exe_* outputs.
  - hazard: load a bubble; id_stall_req=1.
  - otherwise: load the decoded id_inst. exe_valid=id_valid; if id_valid=0, all control bits are 0.
- A bubble sets exe_valid, reg_write, mem_read, mem_write, branch, jump and illegal to 0. Field outputs (alu_op, funct, rd, rs) are 0 in a bubble.
- id_stall_req is forced 0 while stall=1 or flush=1.

## Timing
- Reset (asynchronous assert, synchronous release): every exe_* output is 0; id_stall_req follows its combinational equation, which is 0 because exe_valid=0.
- Latency: 1 cycle from id_inst at an edge to exe_* after that edge.
- A hazard bubble lasts exactly one cycle. On the next cycle exe_mem_read=0, so id_stall_req drops and the held instruction enters EXE.
- flush and hazard together: the bubble is loaded and id_stall_req=0.
- stall and flush together: the flush wins and the bubble is loaded.
- Reset asserted mid-stall: the state clears immediately; no pending hazard survives.

## Configuration
- HAZARD_DETECT_EN defined: load-use detection and bubble insertion as above.
- HAZARD_DETECT_EN undefined: id_stall_req is tied 0 and the hazard term is removed from the priority chain. Software or forwarding is responsible for load-use hazards.

## Test plan
- Reset low → all exe_* outputs 0; release, then add x3,x1,x2 (0x002081B3) → next cycle alu_op=000, funct3=000, funct7=0, rd=3, reg_write=1, exe_valid=1.
- srai x4,x4,3 (0x40325213) → alu_op=001, funct3=101, funct7=0100000; addi x4,x4,-1 → funct7=0.
- lw x5,0(x1), then add x6,x5,x1 → id_stall_req=1 for one cycle, one bubble (exe_valid=0), then add in EXE; with rd=x0 → no stall.
- stall=1 for 3 cycles with new id_inst → exe_* unchanged; stall=1 and flush=1 together → bubble loaded.
- Opcode 0x7F → exe_illegal=1, exe_valid=0, reg_write=0; the next legal instruction clears exe_illegal.
- HAZARD_DETECT_EN undefined, lw/add pair → id_stall_req=0 and add enters EXE directly after lw.
